axis_demux: RTL
===============

Name: axis_demux

Overview:
- Single AXIS input fanned out to NUM_SINKS AXIS outputs; packet-level routing.
- Destination index sits in a field of each packet's first (header) beat. The whole packet, header included, goes to that sink.
- One first-word-fall-through FIFO per sink, so a stalled sink holds back only the packets routed to it; head-of-line blocking at the input is accepted.
- Counterpart of the multi-source AXIS mux: it splits a merged stream back out per destination. Handshake is valid/ready throughout.

Parameters:
- FIFO_DEPTH, 8, entries per sink FIFO (data + last bit).
- DATA_WIDTH, 32, beat width.
- NUM_SINKS, 2, number of outputs; legal range 2..8; elaboration error outside it.
- DEST_LSB, 24, LSB of destination field in header beat.
- Derived: DEST_W = $clog2(NUM_SINKS). Elaboration error if DEST_LSB+DEST_W > DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_last  in  1  last beat of packet
- s_data  in  DATA_WIDTH  input beat
- m_valid  out  NUM_SINKS  per-sink valid
- m_ready  in  NUM_SINKS  per-sink ready
- m_last  out  NUM_SINKS  per-sink last
- m_data  out  DATA_WIDTH*NUM_SINKS  sink k on bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- drop_count  out  16  packets discarded for out-of-range destination

Behaviour:
- Reset:
  - State goes to HEADER.
  - All FIFOs are emptied (pointers cleared, count 0), so m_valid=0 on all sinks the cycle after rst is sampled.
  - s_ready=0 while rst is high. drop_count=0.
  - Reset mid-packet discards FIFO contents and any partial packet. The upstream is reset in the same domain, so there is no resync.
- State HEADER:
  - dest = s_data[DEST_LSB +: DEST_W], decoded combinationally.
  - dest < NUM_SINKS: s_ready = !full[dest]. On acceptance, write {s_last, s_data} to FIFO[dest] and latch dest.
    - s_last=0: go to FORWARD.
    - s_last=1 (single-beat packet): stay in HEADER.
  - dest >= NUM_SINKS (only possible when NUM_SINKS is not a power of 2): s_ready=1 and the beat is discarded.
    - drop_count increments, saturating at 16'hFFFF.
    - s_last=0: go to DROP.
    - s_last=1: stay in HEADER.
- State FORWARD:
  - s_ready = !full[latched dest]. Accepted beats are written to FIFO[latched dest].
  - Accepted beat with s_last=1: return to HEADER.
  - Field bits in non-header beats are ignored.
- State DROP:
  - s_ready=1; beats are discarded.
  - Accepted beat with s_last=1: return to HEADER.
- full[k] = (count[k] == FIFO_DEPTH). Writing a full FIFO is impossible by construction; the bench asserts it never happens.
- Output k:
  - m_valid[k] = !empty[k]; m_data/m_last come from the FIFO head.
  - Read when m_valid[k] && m_ready[k].
  - A simultaneous read and write on a full FIFO is not permitted: s_ready uses full only, not read-ahead.
- Latency: beat accepted at edge N is visible on m_valid/m_data after edge N+1 (one cycle). With m_ready held high, throughput is one beat per cycle.
- Ordering: per sink, beats leave in arrival order. Packets from one input never interleave on a sink.
- m_valid must not drop and m_data must not change while m_valid && !m_ready (FIFO head is stable).
- s_ready may depend combinationally on s_data in HEADER state. It is registered-free but has no path from m_ready to s_ready in the same cycle beyond the FIFO count.

Optional Feature:
- AXIS_DEMUX_DROP_CNT_EN
  - Defined: drop_count behaves as above.
  - Undefined: drop_count is tied to 16'h0 and the counter logic is removed. Out-of-range packets are still dropped identically.

Test Plan:
- NUM_SINKS=2, m_ready all high. Send a 4-beat packet with header dest=1, then a 3-beat packet with dest=0 -> sink1 receives exactly 4 beats (last on beat 4), then sink0 receives 3. Each beat appears one cycle after acceptance. drop_count=0.
- m_ready[0]=0. Send a 10-beat packet to sink0 with FIFO_DEPTH=8 -> s_ready falls after 8 accepted beats. Releasing m_ready[0] drains all 10 beats in order with no loss or duplication.
- NUM_SINKS=3, header dest=3 on a 5-beat packet, then a dest=2 packet -> the 5 beats are accepted with s_ready=1 and no m_valid asserted. drop_count=1. The next packet is delivered on sink2.
- Back-to-back single-beat packets (s_last=1) to dest 0,1,0,1 -> each sink receives 2 one-beat packets. State stays in HEADER throughout.
- Assert rst for 1 cycle mid-packet with sink0 FIFO holding 5 entries -> the cycle after, all m_valid=0 and drop_count=0. The next header is routed correctly.
- Random valid/ready traffic for 10k beats against a scoreboard, with and without AXIS_DEMUX_DROP_CNT_EN -> zero mismatches. drop_count equals the number of out-of-range headers, or 0 when the macro is undefined.

Source files
------------

// File: rtl/axis_demux_if.sv
// Signal bundle for axis_demux: one input AXIS stream, NUM_SINKS output streams.
// slave is the demux's own view; master is the view of the source and sinks around it.
interface axis_demux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SINKS  = 2
);
  logic                            s_valid;
  logic                            s_ready;
  logic                            s_last;
  logic [DATA_WIDTH-1:0]           s_data;
  logic [NUM_SINKS-1:0]            m_valid;
  logic [NUM_SINKS-1:0]            m_ready;
  logic [NUM_SINKS-1:0]            m_last;
  logic [DATA_WIDTH*NUM_SINKS-1:0] m_data;

  modport slave (
    input  s_valid, s_last, s_data, m_ready,
    output s_ready, m_valid, m_last, m_data
  );

  modport master (
    output s_valid, s_last, s_data, m_ready,
    input  s_ready, m_valid, m_last, m_data
  );
endinterface

// File: rtl/axis_demux.sv
// Packet-level AXIS demux: the header beat's dest field routes the whole packet to one per-sink FWFT FIFO.
// Define AXIS_DEMUX_DROP_CNT_EN to count packets dropped for an out-of-range destination.
module axis_demux #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SINKS  = 2,
  parameter int DEST_LSB   = 24
) (
  input  logic        clk,
  input  logic        rst,
  axis_demux_if.slave bus,
  output logic [15:0] drop_count
);
  localparam int DEST_W    = $clog2(NUM_SINKS);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam bit DEST_POW2 = ((1 << DEST_W) == NUM_SINKS);

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_FORWARD = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  if (NUM_SINKS < 2 || NUM_SINKS > 8) begin : g_bad_sinks
    $error("axis_demux: NUM_SINKS must be in 2..8");
  end
  if (DEST_LSB + DEST_W > DATA_WIDTH) begin : g_bad_dest
    $error("axis_demux: destination field exceeds DATA_WIDTH");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("axis_demux: FIFO_DEPTH must be at least 2");
  end

  logic [1:0]           state;
  logic [DEST_W-1:0]    dest_q;
  logic [DEST_W-1:0]    hdr_dest;
  logic [DEST_W-1:0]    cur_dest;
  logic                 dest_ok;
  logic                 route;
  logic                 sel_full;
  logic                 accept;
  logic [NUM_SINKS-1:0] full;
  logic [NUM_SINKS-1:0] wr_en;
  logic [NUM_SINKS-1:0] rd_en;
  logic [PTR_W-1:0]     wr_ptr [NUM_SINKS];
  logic [PTR_W-1:0]     rd_ptr [NUM_SINKS];
  logic [CNT_W-1:0]     count  [NUM_SINKS];
  logic [DATA_WIDTH:0]  mem    [NUM_SINKS][FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Out-of-range destinations exist only when NUM_SINKS is not a power of two.
  assign hdr_dest = bus.s_data[DEST_LSB +: DEST_W];
  assign dest_ok  = DEST_POW2 || ({1'b0, hdr_dest} < (DEST_W + 1)'(NUM_SINKS));

  // NOTE: sel_full gets a default before the loop so this block can never infer a latch.
  always_comb begin
    cur_dest = (state == ST_HEADER) ? hdr_dest : dest_q;
    route    = (state == ST_FORWARD) || ((state == ST_HEADER) && dest_ok);
    sel_full = 1'b0;
    for (int k = 0; k < NUM_SINKS; k++) begin
      full[k] = (count[k] == CNT_W'(FIFO_DEPTH));
      if (cur_dest == DEST_W'(k)) sel_full = full[k];
    end

    if (rst)        bus.s_ready = 1'b0;
    else if (route) bus.s_ready = !sel_full;
    else            bus.s_ready = 1'b1;
    accept = bus.s_valid && bus.s_ready;

    for (int k = 0; k < NUM_SINKS; k++) begin
      wr_en[k]       = accept && route && (cur_dest == DEST_W'(k));
      bus.m_valid[k] = (count[k] != '0);
      rd_en[k]       = bus.m_valid[k] && bus.m_ready[k];
      {bus.m_last[k], bus.m_data[k*DATA_WIDTH +: DATA_WIDTH]} = mem[k][rd_ptr[k]];
    end
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_HEADER;
      dest_q <= '0;
    end else if (accept) begin
      case (state)
        ST_HEADER: begin
          dest_q <= hdr_dest;
          if (!bus.s_last) state <= dest_ok ? ST_FORWARD : ST_DROP;
        end
        default: if (bus.s_last) state <= ST_HEADER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SINKS; k++) begin
      if (rst) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end else begin
        if (wr_en[k]) wr_ptr[k] <= ptr_next(wr_ptr[k]);
        if (rd_en[k]) rd_ptr[k] <= ptr_next(rd_ptr[k]);
        case ({wr_en[k], rd_en[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count gates every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SINKS; k++) begin
      if (wr_en[k]) mem[k][wr_ptr[k]] <= {bus.s_last, bus.s_data};
    end
  end

`ifdef AXIS_DEMUX_DROP_CNT_EN
  logic drop_hdr;
  assign drop_hdr = accept && (state == ST_HEADER) && !dest_ok;

  always_ff @(posedge clk) begin
    if (rst)                                      drop_count <= '0;
    else if (drop_hdr && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`else
  assign drop_count = 16'h0;
`endif
endmodule
